// File: rtl/instr_decode_reg_pkg.sv
// Shared constants and types for the registered instruction decode stage:
// field widths and positions, opcode values and the occupancy state encoding.
package instr_decode_reg_pkg;

  localparam int INSTRWIDTH = 16;
  localparam int IMMWIDTH   = 8;
  localparam int FIELDWIDTH = 4;

  localparam int OPC_LSB   = 12;
  localparam int RDEST_LSB = 8;
  localparam int EXT_LSB   = 4;
  localparam int RSRC_LSB  = 0;
  localparam int IMM_LSB   = 0;

  localparam logic [3:0] OP_REG  = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_XORI = 4'b0011;
  localparam logic [3:0] OP_MEM  = 4'b0100;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/instr_decode_reg_fields.sv
// Purely combinational field splitter: one 16-bit instruction word in,
// register/immediate fields and the two immediate-class flags out.
module instr_fields
  import instr_decode_reg_pkg::*;
(
  input  logic [INSTRWIDTH-1:0] instr,
  output logic [FIELDWIDTH-1:0] opcode,
  output logic [FIELDWIDTH-1:0] ext,
  output logic [FIELDWIDTH-1:0] rdest,
  output logic [FIELDWIDTH-1:0] rsrc,
  output logic [IMMWIDTH-1:0]   imm,
  output logic                  is_imm,
  output logic                  imm_zext
);

  assign opcode = instr[OPC_LSB   +: FIELDWIDTH];
  assign rdest  = instr[RDEST_LSB +: FIELDWIDTH];
  assign ext    = instr[EXT_LSB   +: FIELDWIDTH];
  assign rsrc   = instr[RSRC_LSB  +: FIELDWIDTH];
  assign imm    = instr[IMM_LSB   +: IMMWIDTH];

  // Register-form and memory-form instructions carry no immediate operand.
  assign is_imm   = (opcode != OP_REG) && (opcode != OP_MEM);
  assign imm_zext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);

endmodule

// File: rtl/instr_decode_reg.sv
// Registered decode stage with a 2-entry skid buffer: main register drives the
// decoded outputs, skid register absorbs one word so in_ready can be registered.
module instr_decode_reg
  import instr_decode_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [INSTRWIDTH-1:0] in_instr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIELDWIDTH-1:0] opcode,
  output logic [FIELDWIDTH-1:0] ext,
  output logic [FIELDWIDTH-1:0] rdest,
  output logic [FIELDWIDTH-1:0] rsrc,
  output logic [IMMWIDTH-1:0]   imm,
  output logic                  is_imm,
  output logic                  imm_zext,
  output logic [1:0]            dbg_state
);

  // Handshake: a word moves across a port only at a rising edge where both
  // valid and ready are 1; in_ready comes from a flop, never from out_ready.

  occ_state_e            r_state;
  occ_state_e            w_state_nxt;
  logic                  r_in_ready;
  logic [INSTRWIDTH-1:0] r_main;
  logic [INSTRWIDTH-1:0] r_skid;
  logic                  w_main_vld;
  logic                  w_in_xfer;
  logic                  w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = w_main_vld && out_ready;
  assign in_ready   = r_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_FULL;
        else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_out_xfer) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  always_comb begin
    w_main_vld = (r_state != ST_EMPTY);
    out_valid  = w_main_vld;
    dbg_state  = r_state;
  end

  // A flushed word is dropped by the state change alone; data regs keep their
  // contents so the field outputs stay stable until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) r_main <= in_instr;
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) r_main <= in_instr;
          else if (w_in_xfer)          r_skid <= in_instr;
        end
        ST_FULL:  if (w_out_xfer) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  instr_fields u_fields (
    .instr    (r_main),
    .opcode   (opcode),
    .ext      (ext),
    .rdest    (rdest),
    .rsrc     (rsrc),
    .imm      (imm),
    .is_imm   (is_imm),
    .imm_zext (imm_zext)
  );

endmodule

// File: tb/tb_instr_decode_reg.sv
// Bench for instr_decode_reg: directed scenarios with literal expectations plus
// a randomized phase checked every cycle against a FIFO-level reference model.
module tb_instr_decode_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [3:0]  ext;
  logic [3:0]  rdest;
  logic [3:0]  rsrc;
  logic [7:0]  imm;
  logic        is_imm;
  logic        imm_zext;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_decode_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .ext       (ext),
    .rdest     (rdest),
    .rsrc      (rsrc),
    .imm       (imm),
    .is_imm    (is_imm),
    .imm_zext  (imm_zext),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stage viewed as a 2-deep FIFO; m_main is the word the outputs decode,
  // which keeps its last value while the FIFO is empty.
  logic [15:0] exp_q[$];
  logic [15:0] m_main;
  logic        m_rdy  = 1'b1;
  logic        m_live = 1'b0;

  always @(posedge clk) begin : model
    bit ix, ox;
    ix = in_valid && m_rdy;
    ox = (exp_q.size() > 0) && out_ready;
    if (reset) begin
      exp_q.delete();
      m_main = 16'h0000;
      m_rdy  = 1'b1;
      m_live = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      m_rdy = 1'b1;
    end else begin
      if (ox) void'(exp_q.pop_front());
      if (ix) exp_q.push_back(in_instr);
      if (exp_q.size() > 0) m_main = exp_q[0];
      m_rdy = (exp_q.size() < 2);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      logic [3:0] op;
      op = m_main[15:12];
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("in_ready",  in_ready,  m_rdy);
      chk("opcode",    opcode,    op);
      chk("rdest",     rdest,     m_main[11:8]);
      chk("ext",       ext,       m_main[7:4]);
      chk("rsrc",      rsrc,      m_main[3:0]);
      chk("imm",       imm,       m_main[7:0]);
      chk("is_imm",    is_imm,    (op != 4'd0) && (op != 4'd4));
      chk("imm_zext",  imm_zext,  (op >= 4'd1) && (op <= 4'd3));
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic v, input logic [15:0] w, input logic ordy,
                     input logic fl, input logic rs);
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    logic        v;
    logic        taken;
    logic [15:0] sx;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 16'hABCD; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_fields",    {opcode, ext, rdest, rsrc, imm, is_imm, imm_zext}, 32'h0);

    // streaming, first edge after release accepts
    cyc(1'b1, 16'h5123, 1'b1, 1'b0, 1'b0);
    chk("s0_valid", out_valid, 1'b1);
    chk("s0_fields", {opcode, rdest, imm, is_imm}, {4'h5, 4'h1, 8'h23, 1'b1});
    cyc(1'b1, 16'h0A4F, 1'b1, 1'b0, 1'b0);
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_fields", {opcode, rsrc, is_imm}, {4'h0, 4'hF, 1'b0});
    cyc(1'b1, 16'h1FFF, 1'b1, 1'b0, 1'b0);
    chk("s2_valid", out_valid, 1'b1);
    chk("s2_fields", {opcode, imm, imm_zext}, {4'h1, 8'hFF, 1'b1});
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("s_drain", out_valid, 1'b0);

    // backpressure: 3 stalled cycles then release
    cyc(1'b1, 16'h2101, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy1", in_ready, 1'b1);
    cyc(1'b1, 16'h2202, 1'b0, 1'b0, 1'b0);
    chk("bp_full_rdy", in_ready, 1'b0);
    cyc(1'b1, 16'h2303, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_imm", imm, 8'h01);
    // skid boundary: one out transfer from FULL, offered word refused this edge
    cyc(1'b1, 16'h2303, 1'b1, 1'b0, 1'b0);
    chk("skid_imm", imm, 8'h02);
    chk("skid_rdy", in_ready, 1'b1);
    cyc(1'b1, 16'h2303, 1'b1, 1'b0, 1'b0);
    chk("bp_w3", imm, 8'h03);
    cyc(1'b1, 16'h2404, 1'b1, 1'b0, 1'b0);
    chk("bp_w4", imm, 8'h04);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("bp_drain", out_valid, 1'b0);

    // flush while FULL with simultaneous in and out
    cyc(1'b1, 16'h3A01, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h3A02, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h3A03, 1'b1, 1'b1, 1'b0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_rdy",   in_ready,  1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("fl_after", out_valid, 1'b0);

    // immediate sweep with downstream sign extension
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, {8'h52, i[7:0]}, 1'b1, 1'b0, 1'b0);
      sx = {{8{imm[7]}}, imm};
      chk("sw_imm", imm, i[7:0]);
      chk("sw_sext", sx, {{8{i[7]}}, i[7:0]});
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // randomized phase; an offered word is held until taken (flush/reset consume it)
    v = 1'b0; w = 16'h0000; taken = 1'b0;
    repeat (3000) begin
      logic fl, rs, ordy;
      if (!v || taken) begin
        v = ($urandom_range(0, 3) != 0);
        w = 16'($urandom);
      end
      fl   = ($urandom_range(0, 31) == 0);
      rs   = ($urandom_range(0, 199) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      taken = v && (in_ready || fl || rs);
      cyc(v, w, ordy, fl, rs);
    end
    repeat (4) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
